bicubic_2d_engine: RTL and testbench

BICUBIC_2D_ENGINE -- requirements
Module: bicubic_2d_engine

---
 rtl/bicubic_2d_engine.sv | 142 ++++++++++++++
 tb/tb_bicubic_2d_engine.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bicubic_2d_engine.sv
// Bicubic (Catmull-Rom, a=-0.5) interpolator over a 4x4 window: weights, four row passes, one column pass.
// Build option: define BICUBIC_ROUND_EN for round-half-up reductions; the default reduces by floor.
module bicubic_2d_engine #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [16*DATA_W-1:0] win,
  input  logic [FRAC_W-1:0]    fx,
  input  logic [FRAC_W-1:0]    fy,
  output logic [DATA_W-1:0]    out_val,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int W_W   = FRAC_W + 3;
  localparam int H_W   = DATA_W + 3;
  localparam int VAC_W = W_W + H_W + 2;
  // One signed working width big enough for t*t and for every weighted sum.
  localparam int RED_W = (VAC_W > 2 * FRAC_W + 2) ? VAC_W : 2 * FRAC_W + 2;

  typedef enum logic [2:0] {IDLE, WGT, HROW, VERT, DONE} state_t;
  typedef logic signed [W_W-1:0] weight_t;
  typedef weight_t [3:0]         wvec_t;
  typedef logic signed [H_W-1:0] hval_t;
  typedef logic signed [RED_W-1:0] acc_t;

  state_t               state, state_n;
  logic [1:0]           row;
  logic [16*DATA_W-1:0] win_q;
  logic [FRAC_W-1:0]    fx_q, fy_q;
  wvec_t                wx, wy;
  hval_t [3:0]          h;

  function automatic acc_t reduce(input acc_t a);
    acc_t half;
    half = acc_t'(1) <<< (FRAC_W - 1);
`ifdef BICUBIC_ROUND_EN
    reduce = (a + half) >>> FRAC_W;
`else
    half = '0;
    reduce = (a + half) >>> FRAC_W;
`endif
  endfunction

  // w2 takes whatever the other three leave, so the weights always sum to exactly one.
  function automatic wvec_t calc_weights(input logic [FRAC_W-1:0] t);
    acc_t tt, t2, t3, unity, h0, h1, h3;
    tt    = acc_t'(t);
    unity = acc_t'(1) <<< FRAC_W;
    t2    = reduce(tt * tt);
    t3    = reduce(t2 * tt);
    h0    = (t2 + t2 - t3 - tt) >>> 1;
    h1    = (t3 + t3 + t3 - (t2 <<< 2) - t2 + (unity <<< 1)) >>> 1;
    h3    = (t3 - t2) >>> 1;
    calc_weights[0] = weight_t'(h0);
    calc_weights[1] = weight_t'(h1);
    calc_weights[2] = weight_t'(unity - h0 - h1 - h3);
    calc_weights[3] = weight_t'(h3);
  endfunction

  function automatic acc_t row_sum(input wvec_t w, input logic [4*DATA_W-1:0] px);
    acc_t acc;
    acc = '0;
    for (int c = 0; c < 4; c++)
      acc = acc + acc_t'(w[c]) * acc_t'($signed({1'b0, px[c*DATA_W +: DATA_W]}));
    row_sum = acc;
  endfunction

  function automatic acc_t col_sum(input wvec_t w, input hval_t [3:0] hv);
    acc_t acc;
    acc = '0;
    for (int r = 0; r < 4; r++)
      acc = acc + acc_t'(w[r]) * acc_t'(hv[r]);
    col_sum = acc;
  endfunction

  function automatic logic [DATA_W-1:0] clamp_pix(input acc_t v);
    acc_t pix_max;
    pix_max = (acc_t'(1) <<< DATA_W) - acc_t'(1);
    if (v < 0)
      clamp_pix = '0;
    else if (v > pix_max)
      clamp_pix = '1;
    else
      clamp_pix = v[DATA_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      row     <= 2'd0;
      out_val <= '0;
    end else begin
      state <= state_n;
      if (state == HROW)
        row <= row + 2'd1;
      if (state == VERT)
        out_val <= clamp_pix(reduce(col_sum(wy, h)));
    end
  end

  // NOTE: datapath registers carry no reset; each is written before the FSM ever reads it.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      win_q <= win;
      fx_q  <= fx;
      fy_q  <= fy;
    end
    if (state == WGT) begin
      wx <= calc_weights(fx_q);
      wy <= calc_weights(fy_q);
    end
    if (state == HROW)
      h[row] <= hval_t'(reduce(row_sum(wx, win_q[row*4*DATA_W +: 4*DATA_W])));
  end

  // NOTE: every output of this block is assigned a default first, so no latch is inferred.
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = WGT;
      end
      WGT:  state_n = HROW;
      HROW: if (row == 2'd3) state_n = VERT;
      VERT: state_n = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bicubic_2d_engine.sv
// Self-checking bench for bicubic_2d_engine: vector table plus random windows against an integer model.
module tb_bicubic_2d_engine;

  localparam int DW = 8;
  localparam int FW = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [16*DW-1:0] win = '0;
  logic [FW-1:0]    fx = '0;
  logic [FW-1:0]    fy = '0;
  logic [DW-1:0]    out_val;
  logic             out_valid;
  logic             out_ready = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string            name;
    logic [16*DW-1:0] win;
    int               fx;
    int               fy;
    int               exp;
  } vec_t;

  vec_t tbl[$];

  bicubic_2d_engine #(.DATA_W(DW), .FRAC_W(FW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .win       (win),
    .fx        (fx),
    .fy        (fy),
    .out_val   (out_val),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic with mathematical floor division.
  function automatic longint fdiv(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint reduce_m(input longint a);
    longint s;
    s = longint'(1) << FW;
`ifdef BICUBIC_ROUND_EN
    return fdiv(a + s / 2, s);
`else
    return fdiv(a, s);
`endif
  endfunction

  function automatic longint weight_m(input longint t, input int idx);
    longint one, t2, t3, w0, w1, w3;
    one = longint'(1) << FW;
    t2  = reduce_m(t * t);
    t3  = reduce_m(t2 * t);
    w0  = fdiv(-t3 + 2 * t2 - t, 2);
    w1  = fdiv(3 * t3 - 5 * t2 + 2 * one, 2);
    w3  = fdiv(t3 - t2, 2);
    case (idx)
      0:       return w0;
      1:       return w1;
      3:       return w3;
      default: return one - w0 - w1 - w3;
    endcase
  endfunction

  function automatic int model(input logic [16*DW-1:0] w, input int x, input int y);
    longint hrow[4];
    longint acc, v;
    for (int r = 0; r < 4; r++) begin
      acc = 0;
      for (int c = 0; c < 4; c++)
        acc += weight_m(x, c) * longint'(w[(4*r+c)*DW +: DW]);
      hrow[r] = reduce_m(acc);
    end
    acc = 0;
    for (int r = 0; r < 4; r++)
      acc += weight_m(y, r) * hrow[r];
    v = reduce_m(acc);
    if (v < 0) v = 0;
    if (v > (1 << DW) - 1) v = (1 << DW) - 1;
    return int'(v);
  endfunction

  function automatic logic [16*DW-1:0] rows_of(input logic [4*DW-1:0] one_row);
    return {4{one_row}};
  endfunction

  function automatic logic [16*DW-1:0] rand_win();
    logic [16*DW-1:0] w;
    for (int i = 0; i < 16; i++) w[i*DW +: DW] = DW'($urandom);
    return w;
  endfunction

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, " in_ready"}, 32'(in_ready), 1);
  endtask

  // Issue one request, return latency in edges and the value seen when out_valid rose.
  task automatic issue(input logic [16*DW-1:0] w, input int x, input int y,
                       output int lat, output int got);
    win = w;
    fx = FW'(x);
    fy = FW'(y);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    got = int'(out_val);
  endtask

  task automatic do_txn(input string name, input logic [16*DW-1:0] w, input int x, input int y,
                        input int exp);
    int lat, got;
    wait_ready(name);
    issue(w, x, y, lat, got);
    check({name, " latency"}, 32'(lat), 6);
    check({name, " out_val"}, 32'(got), 32'(exp));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({name, " back to idle"}, 32'(in_ready), 1);
  endtask

  initial begin
    logic [16*DW-1:0] w;
    int lat, got, held;

    vec_t v;
    w = rand_win();
    w[5*DW +: DW] = DW'(173);
    v = '{"identity", w, 0, 0, 173};                        tbl.push_back(v);
    v = '{"uniform", {16{8'd100}}, 77, 200, 100};          tbl.push_back(v);
    v = '{"clamp_low", rows_of({8'd0, 8'd0, 8'd0, 8'd255}), 128, 0, 0};   tbl.push_back(v);
    v = '{"clamp_high", rows_of({8'd0, 8'd255, 8'd255, 8'd0}), 128, 0, 255}; tbl.push_back(v);
    v = '{"max_frac", {16{8'd255}}, 255, 255, 255};        tbl.push_back(v);
    w = rand_win();
    v = '{"half_half", w, 128, 128, model(w, 128, 128)};   tbl.push_back(v);
    for (int i = 0; i < 24; i++) begin
      int x, y;
      w = rand_win();
      x = int'($urandom_range(0, (1 << FW) - 1));
      y = int'($urandom_range(0, (1 << FW) - 1));
      v = '{$sformatf("rand%0d", i), w, x, y, model(w, x, y)};
      tbl.push_back(v);
    end

    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 1);
    check("reset out_valid", 32'(out_valid), 0);
    check("reset out_val", 32'(out_val), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) do_txn(tbl[i].name, tbl[i].win, tbl[i].fx, tbl[i].fy, tbl[i].exp);

    // Backpressure: hold out_ready low three cycles, then accept while a new request is pending.
    w = rand_win();
    wait_ready("bp");
    issue(w, 50, 190, lat, got);
    check("bp latency", 32'(lat), 6);
    check("bp out_val", 32'(got), 32'(model(w, 50, 190)));
    held = got;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("bp out_valid held", 32'(out_valid), 1);
      check("bp out_val stable", 32'(out_val), 32'(held));
      check("bp in_ready low", 32'(in_ready), 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("bp in_ready after accept", 32'(in_ready), 1);
    check("bp out_valid after accept", 32'(out_valid), 0);

    // Reset while the row pass is on row 2.
    w = rand_win();
    wait_ready("rst_mid");
    win = w;
    fx = FW'(33);
    fy = FW'(99);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid out_valid", 32'(out_valid), 0);
    check("rst_mid in_ready", 32'(in_ready), 1);
    check("rst_mid out_val", 32'(out_val), 0);
    @(negedge clk);
    rst = 1'b0;
    w = rand_win();
    do_txn("after_rst", w, 211, 17, model(w, 211, 17));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
